// File: rtl/exu_regrd_arb.sv
// exu_regrd_arb
//   Shares the two register-file read ports among NREQ EXU sub-units.
//   One requester is granted per cycle in round-robin order. The RF ports
//   are driven from registers, and the synchronous-read data is returned
//   with a one-hot response strobe.
//
//   Pipeline per transaction:
//     ARB     : combinational pick from req_valid & ~pending
//     ISSUE   : gnt, reg_ren_*, reg_raddr_* registered
//     CAPTURE : rsp_valid, rsp_rdata_* registered from reg_rdata_*
//
// Ports
//   hclk, hrst                 clock, async active-high reset
//   req_valid/ren1/ren2        per-requester request and operand enables
//   req_rs1/req_rs2            5-bit register index per requester, slice i
//   exu_stall                  blocks new grants only
//   gnt                        one-hot grant pulse
//   reg_raddr_*/reg_ren_*      RF read port drive
//   reg_rdata_*                RF data, valid the cycle after reg_ren_*
//   rsp_valid, rsp_rdata_*     one-hot response strobe and operand data

// Per-requester outstanding flag. A requester is eligible only while it has
// no transaction in flight.
module exu_regrd_arb_slot (
  input  logic hclk,
  input  logic hrst,
  input  logic req_valid,
  input  logic set,
  input  logic clr,
  output logic elig
);
  logic pending;

  // set and clr never coincide: set needs pending=0 and clr needs pending=1
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst)     pending <= 1'b0;
    else if (set) pending <= 1'b1;
    else if (clr) pending <= 1'b0;
  end

  assign elig = req_valid & ~pending;
endmodule

module exu_regrd_arb #(
  parameter int NREQ = 4
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_ren1,
  input  logic [NREQ-1:0]   req_ren2,
  input  logic [5*NREQ-1:0] req_rs1,
  input  logic [5*NREQ-1:0] req_rs2,
  input  logic              exu_stall,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        reg_raddr_1,
  output logic              reg_ren_1,
  output logic [4:0]        reg_raddr_2,
  output logic              reg_ren_2,
  input  logic [31:0]       reg_rdata_1,
  input  logic [31:0]       reg_rdata_2,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata_1,
  output logic [31:0]       rsp_rdata_2
);
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          ren1;
    logic          ren2;
  } txn_t;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [4:0]      win_rs1;
  logic [4:0]      win_rs2;
  txn_t            win_txn;
  txn_t            iss_q;   // transaction driving the RF ports
  txn_t            rd_q;    // transaction whose data is on reg_rdata_*
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] set_pend;
  logic [NREQ-1:0] clr_pend;
  // [0]: ISSUE stage occupied, [1]: RF data cycle occupied
  logic [STAGES:0] vld_pipe;

  exu_regrd_arb_slot u_slot [NREQ-1:0] (
    .hclk      (hclk),
    .hrst      (hrst),
    .req_valid (req_valid),
    .set       (set_pend),
    .clr       (clr_pend),
    .elig      (elig)
  );

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!exu_stall && !win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    next_ptr     = IW'((int'(win_idx) + 1) % NREQ);
    win_txn.idx  = win_idx;
    win_txn.ren1 = win_found & req_ren1[win_idx];
    win_txn.ren2 = win_found & req_ren2[win_idx];
    // unused ports are driven with address 0 so the RF sees a quiet bus
    win_rs1      = win_txn.ren1 ? req_rs1[5*int'(win_idx) +: 5] : 5'd0;
    win_rs2      = win_txn.ren2 ? req_rs2[5*int'(win_idx) +: 5] : 5'd0;
  end

  always_comb begin
    set_pend = '0;
    if (win_found) set_pend[win_idx] = 1'b1;
    clr_pend = '0;
    if (vld_pipe[1]) clr_pend[rd_q.idx] = 1'b1;
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      rr_ptr      <= '0;
      vld_pipe    <= '0;
      iss_q       <= '0;
      rd_q        <= '0;
      gnt         <= '0;
      reg_ren_1   <= 1'b0;
      reg_ren_2   <= 1'b0;
      reg_raddr_1 <= '0;
      reg_raddr_2 <= '0;
      rsp_valid   <= '0;
      rsp_rdata_1 <= '0;
      rsp_rdata_2 <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], win_found};
      iss_q       <= win_txn;
      rd_q        <= iss_q;
      gnt         <= set_pend;
      reg_ren_1   <= win_txn.ren1;
      reg_ren_2   <= win_txn.ren2;
      reg_raddr_1 <= win_rs1;
      reg_raddr_2 <= win_rs2;
      // response strobe leaves on the same edge that frees the requester
      rsp_valid   <= clr_pend;
      if (vld_pipe[1]) begin
        rsp_rdata_1 <= rd_q.ren1 ? reg_rdata_1 : 32'd0;
        rsp_rdata_2 <= rd_q.ren2 ? reg_rdata_2 : 32'd0;
      end
      if (win_found) rr_ptr <= next_ptr;
    end
  end
endmodule

// File: tb/tb_exu_regrd_arb.sv
module tb_exu_regrd_arb;
  localparam int NREQ = 4;

  logic              hclk = 1'b0;
  logic              hrst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0, req_ren1 = '0, req_ren2 = '0;
  logic [5*NREQ-1:0] req_rs1 = '0, req_rs2 = '0;
  logic              exu_stall = 1'b0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [4:0]        reg_raddr_1, reg_raddr_2;
  logic              reg_ren_1, reg_ren_2;
  logic [31:0]       reg_rdata_1 = '0, reg_rdata_2 = '0;
  logic [31:0]       rsp_rdata_1, rsp_rdata_2;

  int checks = 0;
  int passes = 0;
  logic [31:0] rf_mem [32];

  always #5 hclk = ~hclk;

  exu_regrd_arb #(.NREQ(NREQ)) dut (
    .hclk(hclk), .hrst(hrst), .req_valid(req_valid), .req_ren1(req_ren1),
    .req_ren2(req_ren2), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .exu_stall(exu_stall), .gnt(gnt), .reg_raddr_1(reg_raddr_1),
    .reg_ren_1(reg_ren_1), .reg_raddr_2(reg_raddr_2), .reg_ren_2(reg_ren_2),
    .reg_rdata_1(reg_rdata_1), .reg_rdata_2(reg_rdata_2),
    .rsp_valid(rsp_valid), .rsp_rdata_1(rsp_rdata_1), .rsp_rdata_2(rsp_rdata_2)
  );

  // Synchronous-read register file; junk on the bus when not enabled.
  always @(posedge hclk) begin
    reg_rdata_1 <= reg_ren_1 ? rf_mem[reg_raddr_1] : $urandom;
    reg_rdata_2 <= reg_ren_2 ? rf_mem[reg_raddr_2] : $urandom;
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int         idx;
    logic       r1, r2;
    logic [4:0] a1, a2;
    int         due;
  } mtxn_t;

  mtxn_t           mq[$];
  int              mcyc = 0;
  int              mptr = 0;
  logic [NREQ-1:0] mpend = '0;
  logic [NREQ-1:0] exp_gnt = '0, exp_rsp = '0;
  logic            exp_ren1 = 1'b0, exp_ren2 = 1'b0;
  logic [4:0]      exp_ra1 = '0, exp_ra2 = '0;
  logic [31:0]     exp_rd1 = '0, exp_rd2 = '0;

  initial forever begin
    @(posedge hclk or posedge hrst);
    if (hrst) begin
      mq.delete(); mcyc = 0; mptr = 0; mpend = '0;
      exp_gnt = '0; exp_rsp = '0; exp_ren1 = 0; exp_ren2 = 0;
      exp_ra1 = '0; exp_ra2 = '0; exp_rd1 = '0; exp_rd2 = '0;
    end else begin
      int w;
      mtxn_t t;
      mcyc++;
      w = -1;
      if (!exu_stall)
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (mptr + k) % NREQ;
          if (w < 0 && req_valid[j] && !mpend[j]) w = j;
        end
      exp_rsp = '0;
      if (mq.size() > 0 && mq[0].due == mcyc) begin
        t = mq.pop_front();
        exp_rsp[t.idx] = 1'b1;
        exp_rd1 = t.r1 ? rf_mem[t.a1] : 32'd0;
        exp_rd2 = t.r2 ? rf_mem[t.a2] : 32'd0;
        mpend[t.idx] = 1'b0;
      end
      exp_gnt = '0; exp_ren1 = 0; exp_ren2 = 0; exp_ra1 = '0; exp_ra2 = '0;
      if (w >= 0) begin
        t.idx = w;
        t.r1  = req_ren1[w];
        t.r2  = req_ren2[w];
        t.a1  = req_rs1[5*w +: 5];
        t.a2  = req_rs2[5*w +: 5];
        t.due = mcyc + 2;
        mq.push_back(t);
        exp_gnt[w] = 1'b1;
        exp_ren1 = t.r1; exp_ren2 = t.r2;
        exp_ra1 = t.r1 ? t.a1 : 5'd0;
        exp_ra2 = t.r2 ? t.a2 : 5'd0;
        mpend[w] = 1'b1;
        mptr = (w + 1) % NREQ;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge hclk);
    hrst = 1'b1; req_valid = '0; req_ren1 = '0; req_ren2 = '0;
    req_rs1 = '0; req_rs2 = '0; exu_stall = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    hrst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = '1; req_ren1 = '1; req_ren2 = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge hclk);
      checks++;
      if ({gnt, rsp_valid, reg_ren_1, reg_ren_2, reg_raddr_1, reg_raddr_2,
           rsp_rdata_1, rsp_rdata_2} !== '0)
        $display("FAIL reset_outputs: gnt=%b rsp=%b ren=%b%b ra=%0d/%0d rd=%h/%h, want all 0",
                 gnt, rsp_valid, reg_ren_1, reg_ren_2, reg_raddr_1, reg_raddr_2,
                 rsp_rdata_1, rsp_rdata_2);
      else passes++;
    end
    req_valid = '0; req_ren1 = '0; req_ren2 = '0;
    hrst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_ren1 = 4'b0001; req_ren2 = 4'b0001;
    req_rs1[4:0] = 5'd5; req_rs2[4:0] = 5'd7;
    @(negedge hclk);
    checks++;
    if ({gnt, reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2} !== {4'b0001, 1'b1, 5'd5, 1'b1, 5'd7})
      $display("FAIL single_issue: gnt=%b ren1=%b ra1=%0d ren2=%b ra2=%0d, want 0001 1 5 1 7",
               gnt, reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2);
    else passes++;
    @(negedge hclk);
    checks++;
    if ({gnt, rsp_valid} !== 8'h00)
      $display("FAIL single_gap: gnt=%b rsp=%b, want 0000 0000", gnt, rsp_valid);
    else passes++;
    @(negedge hclk);
    checks++;
    if ({rsp_valid, rsp_rdata_1, rsp_rdata_2} !== {4'b0001, 32'h11, 32'h22})
      $display("FAIL single_rsp: rsp=%b rd1=%h rd2=%h, want 0001 11 22",
               rsp_valid, rsp_rdata_1, rsp_rdata_2);
    else passes++;
    req_valid = '0;
    @(negedge hclk);
    checks++;
    if ({gnt, rsp_valid} !== 8'h00)
      $display("FAIL single_after: gnt=%b rsp=%b, want 0000 0000", gnt, rsp_valid);
    else passes++;
  endtask

  task automatic test_simultaneous();
    int gcnt [NREQ];
    logic [3:0] eg, er;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      gcnt[i] = 0;
      req_rs1[5*i +: 5] = 5'(10 + i);
      req_rs2[5*i +: 5] = 5'(20 + i);
    end
    req_valid = '1; req_ren1 = '1; req_ren2 = '1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge hclk);
      eg = (c <= 4) ? 4'(1 << (c - 1)) : 4'b0;
      er = (c >= 3 && c <= 6) ? 4'(1 << (c - 3)) : 4'b0;
      checks++;
      if ({gnt, rsp_valid} !== {eg, er})
        $display("FAIL simul_order c=%0d: gnt=%b rsp=%b, want %b %b", c, gnt, rsp_valid, eg, er);
      else passes++;
      if (c <= 4) begin
        checks++;
        if (reg_raddr_1 !== 5'(9 + c))
          $display("FAIL simul_raddr c=%0d: ra1=%0d, want %0d", c, reg_raddr_1, 9 + c);
        else passes++;
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if ({rsp_rdata_1, rsp_rdata_2} !== {rf_mem[7 + c], rf_mem[17 + c]})
          $display("FAIL simul_data c=%0d: rd1=%h rd2=%h, want %h %h",
                   c, rsp_rdata_1, rsp_rdata_2, rf_mem[7 + c], rf_mem[17 + c]);
        else passes++;
      end
      for (int i = 0; i < NREQ; i++) begin
        gcnt[i] += int'(gnt[i]);
        if (rsp_valid[i]) req_valid[i] = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (gcnt[i] != 1)
        $display("FAIL simul_once req%0d: granted %0d times, want 1", i, gcnt[i]);
      else passes++;
    end
  endtask

  task automatic test_partial();
    do_reset();
    req_valid = 4'b0100; req_ren1 = 4'b0100; req_ren2 = 4'b0000;
    req_rs1[14:10] = 5'd9; req_rs2[14:10] = 5'd13;
    @(negedge hclk);
    checks++;
    if ({gnt, reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2} !== {4'b0100, 1'b1, 5'd9, 1'b0, 5'd0})
      $display("FAIL partial_issue: gnt=%b ren1=%b ra1=%0d ren2=%b ra2=%0d, want 0100 1 9 0 0",
               gnt, reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2);
    else passes++;
    @(negedge hclk);
    @(negedge hclk);
    checks++;
    if ({rsp_valid, rsp_rdata_1, rsp_rdata_2} !== {4'b0100, rf_mem[9], 32'd0})
      $display("FAIL partial_rsp: rsp=%b rd1=%h rd2=%h, want 0100 %h 0",
               rsp_valid, rsp_rdata_1, rsp_rdata_2, rf_mem[9]);
    else passes++;
    req_valid = '0;
  endtask

  task automatic test_stall();
    logic [3:0] eg;
    do_reset();
    req_valid = 4'b0001; req_ren1 = 4'b0001; req_ren2 = 4'b0001;
    req_rs1[4:0] = 5'd3; req_rs2[4:0] = 5'd4;
    for (int c = 1; c <= 7; c++) begin
      @(negedge hclk);
      eg = (c == 1) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
      checks++;
      if (gnt !== eg)
        $display("FAIL stall_gnt c=%0d: gnt=%b, want %b", c, gnt, eg);
      else passes++;
      if (c == 3) begin
        checks++;
        if ({rsp_valid, rsp_rdata_1} !== {4'b0001, rf_mem[3]})
          $display("FAIL stall_rsp0: rsp=%b rd1=%h, want 0001 %h", rsp_valid, rsp_rdata_1, rf_mem[3]);
        else passes++;
      end
      if (c == 7) begin
        checks++;
        if (rsp_valid !== 4'b0010)
          $display("FAIL stall_rsp1: rsp=%b, want 0010", rsp_valid);
        else passes++;
      end
      if (c == 1) begin
        req_valid[1] = 1'b1; req_ren1[1] = 1'b1; req_rs1[9:5] = 5'd6;
        exu_stall = 1'b1;
      end
      if (c == 3) req_valid[0] = 1'b0;
      if (c == 4) exu_stall = 1'b0;
      if (c == 7) req_valid[1] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100; req_ren1 = 4'b0100; req_ren2 = 4'b0100;
    req_rs1[14:10] = 5'd17; req_rs2[14:10] = 5'd18;
    @(negedge hclk);
    checks++;
    if (gnt !== 4'b0100) $display("FAIL rstmid_gnt: gnt=%b, want 0100", gnt);
    else passes++;
    hrst = 1'b1; req_valid = '0;
    #1;
    checks++;
    if ({gnt, rsp_valid, reg_ren_1, reg_ren_2, reg_raddr_1, reg_raddr_2,
         rsp_rdata_1, rsp_rdata_2} !== '0)
      $display("FAIL rstmid_outputs: gnt=%b rsp=%b ren=%b%b ra=%0d/%0d, want all 0",
               gnt, rsp_valid, reg_ren_1, reg_ren_2, reg_raddr_1, reg_raddr_2);
    else passes++;
    @(negedge hclk);
    @(negedge hclk);
    hrst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      checks++;
      if ({gnt, rsp_valid} !== 8'h00)
        $display("FAIL rstmid_quiet c=%0d: gnt=%b rsp=%b, want 0000 0000", c, gnt, rsp_valid);
      else passes++;
    end
    req_valid = 4'b1010; req_ren1 = 4'b1010; req_ren2 = 4'b0000;
    @(negedge hclk);
    checks++;
    if (gnt !== 4'b0010) $display("FAIL rstmid_first: gnt=%b, want 0010", gnt);
    else passes++;
    @(negedge hclk);
    checks++;
    if (gnt !== 4'b1000) $display("FAIL rstmid_second: gnt=%b, want 1000", gnt);
    else passes++;
    for (int c = 0; c < 2; c++) begin
      @(negedge hclk);
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) req_valid[i] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int c0, g0cnt, c3;
    c0 = -1; g0cnt = 0; c3 = -1;
    do_reset();
    req_valid[3] = 1'b1; req_ren1 = 4'b1001;
    for (int c = 1; c <= 16; c++) begin
      @(negedge hclk);
      if (gnt[0]) begin g0cnt++; c0 = c; end
      if (gnt[3] && c > 4 && c3 < 0) c3 = c;
      if (rsp_valid[0]) req_valid[0] = 1'b0;
      if (!req_valid[3]) req_valid[3] = 1'b1;
      else if (rsp_valid[3]) req_valid[3] = 1'b0;
      if (c == 4) req_valid[0] = 1'b1;
    end
    req_valid = '0;
    checks++;
    if (c0 != 5 || g0cnt != 1)
      $display("FAIL fair_req0: granted at cycle %0d (%0d times), want cycle 5 once", c0, g0cnt);
    else passes++;
    checks++;
    if (c3 != 6) $display("FAIL fair_req3: next grant at cycle %0d, want 6", c3);
    else passes++;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] active;
    active = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge hclk);
      checks++;
      if ({gnt, rsp_valid} !== {exp_gnt, exp_rsp})
        $display("FAIL rand_strobe c=%0d: gnt=%b rsp=%b, want %b %b",
                 c, gnt, rsp_valid, exp_gnt, exp_rsp);
      else passes++;
      checks++;
      if ({reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2} !== {exp_ren1, exp_ra1, exp_ren2, exp_ra2})
        $display("FAIL rand_port c=%0d: ren/ra=%b/%0d %b/%0d, want %b/%0d %b/%0d", c,
                 reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2,
                 exp_ren1, exp_ra1, exp_ren2, exp_ra2);
      else passes++;
      checks++;
      if ({rsp_rdata_1, rsp_rdata_2} !== {exp_rd1, exp_rd2})
        $display("FAIL rand_data c=%0d: rd=%h %h, want %h %h",
                 c, rsp_rdata_1, rsp_rdata_2, exp_rd1, exp_rd2);
      else passes++;
      if (c == 300) begin
        hrst = 1'b1; req_valid = '0; active = '0;
      end else if (c == 302) begin
        hrst = 1'b0;
      end
      if (!hrst) begin
        exu_stall = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < NREQ; i++) begin
          if ((active[i] && rsp_valid[i] && $urandom_range(0, 1) == 1) ||
              (!active[i] && $urandom_range(0, 3) == 0)) begin
            active[i] = 1'b1; req_valid[i] = 1'b1;
            req_ren1[i] = 1'($urandom_range(0, 1));
            req_ren2[i] = 1'($urandom_range(0, 1));
            req_rs1[5*i +: 5] = 5'($urandom);
            req_rs2[5*i +: 5] = 5'($urandom);
          end else if (active[i] && rsp_valid[i]) begin
            active[i] = 1'b0; req_valid[i] = 1'b0;
          end
        end
      end
    end
    req_valid = '0; exu_stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[5] = 32'h11;
    rf_mem[7] = 32'h22;
    test_reset();
    test_single();
    test_simultaneous();
    test_partial();
    test_stall();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/exu_regrd_arb.md
# exu_regrd_arb

Arbiter and sequencer for the two register-file read ports, shared among the EXU sub-units (store, load, ALU, branch). Each sub-unit issues a read request for up to two operands. The block grants one requester per cycle in round-robin order and drives the RF read ports from registers. It captures the synchronous-read data and returns it with a one-hot response strobe. It replaces per-unit gating of the RF read address/enable nets with a single registered driver.

## Interface
- NREQ, 4, number of requesters (2..8); requester index i occupies slice i of every packed vector
- hclk  in  1  clock, all state on rising edge
- hrst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending per requester
- req_ren1  in  NREQ  requester i needs operand 1
- req_ren2  in  NREQ  requester i needs operand 2
- req_rs1  in  5*NREQ  operand-1 register index, slice [5i+4:5i]
- req_rs2  in  5*NREQ  operand-2 register index
- exu_stall  in  1  pipeline stall; blocks new grants
- gnt  out  NREQ  one-hot grant pulse, registered
- reg_raddr_1  out  5  RF read address 1
- reg_ren_1  out  1  RF read enable 1
- reg_raddr_2  out  5  RF read address 2
- reg_ren_2  out  1  RF read enable 2
- reg_rdata_1  in  32  RF read data 1, valid the cycle after reg_ren_1
- reg_rdata_2  in  32  RF read data 2, valid the cycle after reg_ren_2
- rsp_valid  out  NREQ  one-hot response pulse, registered
- rsp_rdata_1  out  32  operand-1 data, shared by all requesters
- rsp_rdata_2  out  32  operand-2 data

## Operation
- Three-stage pipeline per transaction:
  - ARB: sample requests and select a winner.
  - ISSUE: drive the RF ports and gnt.
  - CAPTURE: register the RF data and rsp_valid.
- Eligible set = req_valid & ~pending. pending[i] is set when gnt[i] is issued and cleared when rsp_valid[i] is issued.
- Round-robin selection: search from rr_ptr upward, modulo NREQ. The first eligible index wins.
  - rr_ptr resets to 0.
  - After a grant to index i, rr_ptr = (i+1) mod NREQ.
  - rr_ptr is unchanged when there is no grant.
- No grant when exu_stall=1 or the eligible set is empty. In that cycle gnt=0, reg_ren_1=0, reg_ren_2=0 and both reg_raddr=0.
- ISSUE stage:
  - reg_ren_1 = winner's req_ren1; reg_raddr_1 = winner's req_rs1 if reg_ren_1, else 0.
  - The same rule applies to port 2.
- Requests with ren1=ren2=0 are still granted and answered. The corresponding rsp_rdata field is 0.
- CAPTURE stage:
  - rsp_rdata_1 = reg_rdata_1 if issued ren1 was set, else 0. Same rule for port 2.
  - rsp_rdata_1/2 hold their value until the next rsp_valid.
- Register index 0 is issued to the RF like any other index. Returning zero for x0 is the RF's responsibility.
- exu_stall affects only ARB. A transaction already in ISSUE or CAPTURE completes regardless of stall.
- Requester protocol:
  - Hold req_valid and the operand fields stable until gnt.
  - Deassert req_valid no later than the cycle in which rsp_valid is high.
  - If req_valid is still high after that cycle, it is a new request.
- Reset (any time, including mid-transaction) clears:
  - pending, rr_ptr and all pipeline registers.
  - All outputs, to 0.
  - In-flight transactions are discarded and produce no rsp_valid.

## Timing
- Request sampled at the end of cycle T → gnt and RF port drive in T+1 → RF data in T+2 → rsp_valid and rsp_rdata in T+3. Latency is 3 cycles from sampling to response.
- Throughput is one grant per cycle across different requesters; back-to-back transactions overlap.
- Per requester:
  - pending is set at the T+1 edge and cleared at the T+3 edge.
  - The earliest re-grant to the same requester is from a sample at the end of T+3, giving gnt at T+4.
- gnt and rsp_valid are always one-hot or zero. At most one bit of each is high in any cycle.
- Reset values:
  - gnt=0, rsp_valid=0, reg_ren_1=0, reg_ren_2=0.
  - reg_raddr_1=0, reg_raddr_2=0, rsp_rdata_1=0, rsp_rdata_2=0, rr_ptr=0.

## Test plan
- Single request:
  - Stimulus: requester 0 requests rs1=5, rs2=7, both ren; RF returns 0x11 and 0x22.
  - Required: gnt=0001 at T+1 with reg_raddr_1=5, reg_raddr_2=7; rsp_valid=0001 at T+3 with rsp_rdata_1=0x11, rsp_rdata_2=0x22.
- Simultaneous requests:
  - Stimulus: all 4 requesters request in the same cycle and hold req_valid until their own rsp.
  - Required: grants in order 0,1,2,3 on consecutive cycles; rsp_valid follows in the same order 2 cycles after each grant; no requester is granted twice.
- Partial operands:
  - Stimulus: requester 2 requests with ren1=1, rs1=9, ren2=0.
  - Required: reg_ren_2=0, reg_raddr_2=0; rsp_rdata_2=0; rsp_rdata_1 equals the RF data for x9.
- Stall:
  - Stimulus: exu_stall=1 for 3 cycles while requester 1 is pending, with requester 0 already in ISSUE.
  - Required: requester 0's rsp_valid appears on time; no gnt during the stall; gnt=0010 in the cycle after the stall drops.
- Reset mid-operation:
  - Stimulus: assert hrst while gnt=0100 is in flight.
  - Required: all outputs 0 immediately; no rsp_valid after release; rr_ptr=0, so the next simultaneous requests from 1 and 3 grant 1 first.
- Fairness:
  - Stimulus: requester 3 requests continuously; requester 0 requests once.
  - Required: requester 0 is granted within one grant slot after it becomes eligible.
